// File: rtl/cpu_pkg.sv
// Shared encodings and the decoded control bundle used by the RV32 pipeline stages.
package cpu_pkg;

  localparam logic [1:0] R_TYPE  = 2'b10;
  localparam logic [1:0] I_TYPE  = 2'b00;
  localparam logic [1:0] S_TYPE  = 2'b01;
  localparam logic [1:0] SB_TYPE = 2'b11;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic       RegWrite;
    logic       MemtoReg;
    logic       MemRead;
    logic       MemWrite;
    logic       ALUSrc;
    logic       Branch;
    logic [1:0] ALUOp;
  } ctrl_t;

  // Same bundle Control emits for NoOp: no side effects, R-type ALU class.
  localparam ctrl_t CTRL_BUBBLE = '{RegWrite: 1'b0, MemtoReg: 1'b0, MemRead: 1'b0,
                                    MemWrite: 1'b0, ALUSrc: 1'b0, Branch: 1'b0,
                                    ALUOp: R_TYPE};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches control and operands, detects load-use hazards,
// inserts bubbles on flush or hazard, and counts loaded instructions and bubbles.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             RegWrite_i,
  input  logic             MemtoReg_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic             ALUSrc_i,
  input  logic             Branch_i,
  input  logic [1:0]       ALUOp_i,
  input  logic [9:0]       funct_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  RS1data_i,
  input  logic [XLEN-1:0]  RS2data_i,
  input  logic [XLEN-1:0]  Imm_i,
  input  logic [4:0]       RS1addr_i,
  input  logic [4:0]       RS2addr_i,
  input  logic [4:0]       RDaddr_i,
  output logic             RegWrite_o,
  output logic             MemtoReg_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             ALUSrc_o,
  output logic             Branch_o,
  output logic [1:0]       ALUOp_o,
  output logic [9:0]       funct_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  RS1data_o,
  output logic [XLEN-1:0]  RS2data_o,
  output logic [XLEN-1:0]  Imm_o,
  output logic [4:0]       RS1addr_o,
  output logic [4:0]       RS2addr_o,
  output logic [4:0]       RDaddr_o,
  output logic             valid_o,
  output logic             hazard_o,
  output logic [CNT_W-1:0] insn_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  ctrl_t            ctrl_q;
  logic [9:0]       funct_q;
  logic [XLEN-1:0]  pc_q, rs1_data_q, rs2_data_q, imm_q;
  logic [4:0]       rs1_addr_q, rs2_addr_q, rd_addr_q;
  logic             valid_q;
  logic             load_bubble, load_insn;

  // A load in EX whose destination is read by the instruction in ID.
  assign hazard_o = valid_q & ctrl_q.MemRead & (rd_addr_q != 5'd0) &
                    ((rd_addr_q == RS1addr_i) | (rd_addr_q == RS2addr_i));

  assign load_bubble = flush_i | (~stall_i & hazard_o);
  assign load_insn   = ~flush_i & ~stall_i & ~hazard_o;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ctrl_q     <= '0;
      funct_q    <= '0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
      valid_q    <= 1'b0;
    end else if (load_bubble) begin
      ctrl_q     <= CTRL_BUBBLE;
      funct_q    <= '0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
      valid_q    <= 1'b0;
    end else if (load_insn) begin
      ctrl_q     <= '{RegWrite: RegWrite_i, MemtoReg: MemtoReg_i, MemRead: MemRead_i,
                      MemWrite: MemWrite_i, ALUSrc: ALUSrc_i, Branch: Branch_i,
                      ALUOp: ALUOp_i};
      funct_q    <= funct_i;
      pc_q       <= pc_i;
      rs1_data_q <= RS1data_i;
      rs2_data_q <= RS2data_i;
      imm_q      <= Imm_i;
      rs1_addr_q <= RS1addr_i;
      rs2_addr_q <= RS2addr_i;
      rd_addr_q  <= RDaddr_i;
      valid_q    <= valid_i;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_insn_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (load_insn & valid_i),
    .count (insn_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (load_bubble | (load_insn & ~valid_i)),
    .count (bubble_cnt_o)
  );

  assign RegWrite_o = ctrl_q.RegWrite;
  assign MemtoReg_o = ctrl_q.MemtoReg;
  assign MemRead_o  = ctrl_q.MemRead;
  assign MemWrite_o = ctrl_q.MemWrite;
  assign ALUSrc_o   = ctrl_q.ALUSrc;
  assign Branch_o   = ctrl_q.Branch;
  assign ALUOp_o    = ctrl_q.ALUOp;
  assign funct_o    = funct_q;
  assign pc_o       = pc_q;
  assign RS1data_o  = rs1_data_q;
  assign RS2data_o  = rs2_data_q;
  assign Imm_o      = imm_q;
  assign RS1addr_o  = rs1_addr_q;
  assign RS2addr_o  = rs2_addr_q;
  assign RDaddr_o   = rd_addr_q;
  assign valid_o    = valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: table-driven sequence through a scoreboard queue, plus a
// saturation run on a second instance with 4-bit counters.
module tb_id_ex_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, valid, stall, flush;
  ctrl_t       ci;
  logic [9:0]  funct;
  logic [31:0] pc, rs1d, rs2d, imm;
  logic [4:0]  rs1a, rs2a, rda;

  logic        o_rw, o_mtr, o_mr, o_mw, o_as, o_br, o_valid, o_haz;
  logic [1:0]  o_aluop;
  logic [9:0]  o_funct;
  logic [31:0] o_pc, o_rs1d, o_rs2d, o_imm;
  logic [4:0]  o_rs1a, o_rs2a, o_rda;
  logic [15:0] o_insn, o_bub;

  logic        s_rw, s_mtr, s_mr, s_mw, s_as, s_br, s_valid, s_haz;
  logic [1:0]  s_aluop;
  logic [9:0]  s_funct;
  logic [31:0] s_pc, s_rs1d, s_rs2d, s_imm;
  logic [4:0]  s_rs1a, s_rs2a, s_rda;
  logic [3:0]  s_insn, s_bub;

  id_ex_stage dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .stall_i(stall), .flush_i(flush),
    .RegWrite_i(ci.RegWrite), .MemtoReg_i(ci.MemtoReg), .MemRead_i(ci.MemRead),
    .MemWrite_i(ci.MemWrite), .ALUSrc_i(ci.ALUSrc), .Branch_i(ci.Branch),
    .ALUOp_i(ci.ALUOp), .funct_i(funct), .pc_i(pc), .RS1data_i(rs1d), .RS2data_i(rs2d),
    .Imm_i(imm), .RS1addr_i(rs1a), .RS2addr_i(rs2a), .RDaddr_i(rda),
    .RegWrite_o(o_rw), .MemtoReg_o(o_mtr), .MemRead_o(o_mr), .MemWrite_o(o_mw),
    .ALUSrc_o(o_as), .Branch_o(o_br), .ALUOp_o(o_aluop), .funct_o(o_funct), .pc_o(o_pc),
    .RS1data_o(o_rs1d), .RS2data_o(o_rs2d), .Imm_o(o_imm), .RS1addr_o(o_rs1a),
    .RS2addr_o(o_rs2a), .RDaddr_o(o_rda), .valid_o(o_valid), .hazard_o(o_haz),
    .insn_cnt_o(o_insn), .bubble_cnt_o(o_bub)
  );

  id_ex_stage #(.CNT_W(4)) sat_dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .stall_i(stall), .flush_i(flush),
    .RegWrite_i(ci.RegWrite), .MemtoReg_i(ci.MemtoReg), .MemRead_i(ci.MemRead),
    .MemWrite_i(ci.MemWrite), .ALUSrc_i(ci.ALUSrc), .Branch_i(ci.Branch),
    .ALUOp_i(ci.ALUOp), .funct_i(funct), .pc_i(pc), .RS1data_i(rs1d), .RS2data_i(rs2d),
    .Imm_i(imm), .RS1addr_i(rs1a), .RS2addr_i(rs2a), .RDaddr_i(rda),
    .RegWrite_o(s_rw), .MemtoReg_o(s_mtr), .MemRead_o(s_mr), .MemWrite_o(s_mw),
    .ALUSrc_o(s_as), .Branch_o(s_br), .ALUOp_o(s_aluop), .funct_o(s_funct), .pc_o(s_pc),
    .RS1data_o(s_rs1d), .RS2data_o(s_rs2d), .Imm_o(s_imm), .RS1addr_o(s_rs1a),
    .RS2addr_o(s_rs2a), .RDaddr_o(s_rda), .valid_o(s_valid), .hazard_o(s_haz),
    .insn_cnt_o(s_insn), .bubble_cnt_o(s_bub)
  );

  localparam ctrl_t C_ADD = 8'h82;  // RegWrite, ALUOp=10
  localparam ctrl_t C_LW  = 8'hE8;  // RegWrite, MemtoReg, MemRead, ALUSrc, ALUOp=00
  localparam ctrl_t C_SW  = 8'h19;  // MemWrite, ALUSrc, ALUOp=01
  localparam ctrl_t C_ALL = 8'hFF;

  typedef enum {K_LOAD, K_BUBBLE, K_HOLD, K_ZERO} kind_e;

  typedef struct packed {
    logic        valid;
    ctrl_t       ctrl;
    logic [9:0]  funct;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1a, rs2a, rda;
  } out_t;

  typedef struct {
    logic       rst, valid, stall, flush;
    ctrl_t      c;
    logic [4:0] rs1a, rs2a, rda;
    logic [31:0] pc;
    kind_e      k;
    bit         ch, hz;
    int         insn, bub;
  } vec_t;

  typedef struct {
    out_t o;
    int   insn, bub;
    int   row;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[18];
  int checks = 0;
  int failures = 0;

  function automatic vec_t mk(logic r, logic v, logic s, logic f, ctrl_t c, int a1, int a2,
                              int d, int p, kind_e k, bit ch, bit hz, int insn, int bub);
    vec_t x;
    x.rst = r; x.valid = v; x.stall = s; x.flush = f; x.c = c;
    x.rs1a = 5'(a1); x.rs2a = 5'(a2); x.rda = 5'(d); x.pc = 32'(p);
    x.k = k; x.ch = ch; x.hz = hz; x.insn = insn; x.bub = bub;
    return x;
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst; valid = v.valid; stall = v.stall; flush = v.flush; ci = v.c;
    rs1a = v.rs1a; rs2a = v.rs2a; rda = v.rda; pc = v.pc;
    rs1d = v.pc ^ 32'hA5A5_0000;
    rs2d = v.pc + 32'h100;
    imm  = ~v.pc;
    funct = v.pc[9:0] ^ 10'h2AA;
  endtask

  function automatic out_t from_inputs();
    out_t o;
    o.valid = valid; o.ctrl = ci; o.funct = funct; o.pc = pc; o.rs1d = rs1d;
    o.rs2d = rs2d; o.imm = imm; o.rs1a = rs1a; o.rs2a = rs2a; o.rda = rda;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic compare(input exp_t e);
    string r;
    r = $sformatf("row%0d", e.row);
    check({r, " valid"},  32'(o_valid), 32'(e.o.valid));
    check({r, " ctrl"},   32'({o_rw, o_mtr, o_mr, o_mw, o_as, o_br, o_aluop}), 32'(e.o.ctrl));
    check({r, " funct"},  32'(o_funct), 32'(e.o.funct));
    check({r, " pc"},     o_pc, e.o.pc);
    check({r, " rs1d"},   o_rs1d, e.o.rs1d);
    check({r, " rs2d"},   o_rs2d, e.o.rs2d);
    check({r, " imm"},    o_imm, e.o.imm);
    check({r, " addrs"},  32'({o_rs1a, o_rs2a, o_rda}), 32'({e.o.rs1a, e.o.rs2a, e.o.rda}));
    check({r, " insn"},   32'(o_insn), 32'(e.insn));
    check({r, " bubble"}, 32'(o_bub), 32'(e.bub));
  endtask

  initial begin
    out_t prev, bub_o;
    exp_t e;
    bub_o = '0;
    bub_o.ctrl = CTRL_BUBBLE;
    prev = '0;

    tbl[0]  = mk(0, 1, 0, 0, C_ALL, 5, 5, 5,  'h3C, K_ZERO,   0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, C_ALL, 5, 5, 5,  'h3C, K_ZERO,   1, 0, 0, 0);
    tbl[2]  = mk(1, 1, 0, 0, C_ADD, 1, 2, 3,  'h10, K_LOAD,   1, 0, 1, 0);
    tbl[3]  = mk(1, 1, 0, 0, C_LW,  1, 0, 5,  'h14, K_LOAD,   1, 0, 2, 0);
    tbl[4]  = mk(1, 1, 0, 0, C_ADD, 5, 2, 6,  'h18, K_BUBBLE, 1, 1, 2, 1);
    tbl[5]  = mk(1, 1, 0, 0, C_ADD, 5, 2, 6,  'h18, K_LOAD,   1, 0, 3, 1);
    tbl[6]  = mk(1, 1, 0, 0, C_LW,  3, 0, 0,  'h1C, K_LOAD,   1, 0, 4, 1);
    tbl[7]  = mk(1, 1, 0, 0, C_ADD, 0, 0, 7,  'h20, K_LOAD,   1, 0, 5, 1);
    tbl[8]  = mk(1, 1, 0, 0, C_ADD, 1, 2, 8,  'h40, K_LOAD,   1, 0, 6, 1);
    tbl[9]  = mk(1, 1, 1, 0, C_SW,  8, 8, 1,  'h44, K_HOLD,   1, 0, 6, 1);
    tbl[10] = mk(1, 0, 1, 0, C_LW,  2, 3, 4,  'h48, K_HOLD,   1, 0, 6, 1);
    tbl[11] = mk(1, 1, 1, 0, C_ALL, 8, 8, 8,  'h4C, K_HOLD,   1, 0, 6, 1);
    tbl[12] = mk(1, 1, 1, 1, C_SW,  1, 2, 0,  'h50, K_BUBBLE, 1, 0, 6, 2);
    tbl[13] = mk(1, 0, 0, 0, C_LW,  1, 0, 9,  'h54, K_LOAD,   1, 0, 6, 3);
    tbl[14] = mk(1, 1, 0, 0, C_LW,  2, 9, 9,  'h58, K_LOAD,   1, 0, 7, 3);
    tbl[15] = mk(1, 1, 1, 0, C_ADD, 9, 1, 10, 'h5C, K_HOLD,   1, 1, 7, 3);
    tbl[16] = mk(1, 1, 0, 0, C_ADD, 9, 1, 10, 'h5C, K_BUBBLE, 1, 1, 7, 4);
    tbl[17] = mk(0, 1, 1, 0, C_ALL, 9, 9, 9,  'h60, K_ZERO,   1, 0, 0, 0);

    drive(tbl[0]);
    @(posedge clk);
    #1;
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i]);
      case (tbl[i].k)
        K_LOAD:   e.o = from_inputs();
        K_BUBBLE: e.o = bub_o;
        K_HOLD:   e.o = prev;
        default:  e.o = '0;
      endcase
      e.insn = tbl[i].insn;
      e.bub  = tbl[i].bub;
      e.row  = i;
      prev = e.o;
      sb.push_back(e);
      #3;
      if (tbl[i].ch) check($sformatf("row%0d hazard", i), 32'(o_haz), 32'(tbl[i].hz));
      @(posedge clk);
      #1;
      compare(sb.pop_front());
    end

    // Back-to-back valid ALU ops: 4-bit counter must stick at 15.
    for (int i = 0; i < 20; i++) begin
      drive(mk(1, 1, 0, 0, C_ADD, 1, 2, 3, i * 4, K_LOAD, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      check($sformatf("sat insn %0d", i), 32'(s_insn), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
      check($sformatf("wide insn %0d", i), 32'(o_insn), 32'(i + 1));
    end
    check("sat bubble", 32'(s_bub), 32'd0);
    check("sat pc", s_pc, 32'd76);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RV32 core. Sits directly downstream of the decode Control unit and the register file/immediate generator.
- Latches the decoded control bundle and operands for the EX stage.
- Detects load-use hazards and produces the NoOp request that Control consumes.
- Supports stall (hold) and flush (bubble insertion), and keeps saturating instruction/bubble counters.

Parameters:
- XLEN, 32, data/PC width
- CNT_W, 16, width of performance counters

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-low reset
- valid_i  in  1  ID instruction valid (from IF/ID)
- stall_i  in  1  hold register contents
- flush_i  in  1  replace entry with bubble (branch taken)
- RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, Branch_i  in  1 each  control from Control
- ALUOp_i  in  2  ALU op class
- funct_i  in  10  {funct7, funct3}
- pc_i  in  XLEN  ID PC
- RS1data_i, RS2data_i, Imm_i  in  XLEN  operands
- RS1addr_i, RS2addr_i, RDaddr_i  in  5  register indices
- RegWrite_o … Branch_o, ALUOp_o, funct_o, pc_o, RS1data_o, RS2data_o, Imm_o, RS1addr_o, RS2addr_o, RDaddr_o  out  (matching widths)  registered EX-stage copies
- valid_o  out  1  EX entry holds a real instruction
- hazard_o  out  1  load-use hazard; drives Control NoOp_i, PC/IF-ID stall
- insn_cnt_o  out  CNT_W  valid entries loaded
- bubble_cnt_o  out  CNT_W  bubbles loaded

Behaviour:
- All state updates on posedge clk_i only. Reset is synchronous and active-low: rst_i==0 at a clock edge resets all state.
- Reset state: every output register = 0, valid_o=0, counters=0, so hazard_o=0. ALUOp_o=2'b00 at reset; bubble entries use ALUOp_o=2'b10, the R-type value Control emits for NoOp.
- hazard_o (combinational from registered state and ID inputs): valid_o & MemRead_o & (RDaddr_o!=0) & ((RDaddr_o==RS1addr_i) | (RDaddr_o==RS2addr_i)).
- Per-edge priority: reset > flush_i > stall_i > hazard_o > normal load.
  - flush_i: load bubble. All control bits 0, ALUOp=2'b10, data/address/funct fields 0, valid=0. bubble_cnt +1.
  - stall_i (no flush): hold every register; counters unchanged.
  - hazard_o (no flush/stall): load bubble, same as flush; bubble_cnt +1. The instruction remains in ID because upstream stalls on hazard_o.
  - normal: capture all inputs; valid_o<=valid_i. valid_i=1 increments insn_cnt; valid_i=0 increments bubble_cnt.
- A bubble entry forces controls to 0 even if the inputs are non-zero.
- Counters saturate at 2^CNT_W-1; no wrap.
- Latency: exactly 1 cycle from ID inputs to EX outputs.
- Simultaneous flush_i and stall_i: flush wins.
- Reset while stalled: reset wins and clears everything.
- RDaddr 0 never raises a hazard.

Decomposition:
- Shared package cpu_pkg:
  - ALUOp encodings R_TYPE=2'b10, I_TYPE=2'b00, S_TYPE=2'b01, SB_TYPE=2'b11
  - opcode constants
  - a ctrl_t struct {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, Branch, ALUOp}
  - constant CTRL_BUBBLE
- One natural sub-module: sat_counter (parameter CNT_W; inputs inc, rst_i), instantiated twice.
- Hazard compare stays inline.

Test Plan:
- Reset: rst_i=0 for 2 cycles with all inputs non-zero → all outputs 0, hazard_o=0, counters 0.
- Normal flow: add x3,x1,x2 (RegWrite=1, ALUOp=10, RDaddr=3, valid_i=1) → next cycle outputs mirror inputs, valid_o=1, insn_cnt=1.
- Load-use: EX holds lw x5 (MemRead=1, RDaddr=5); ID RS1addr_i=5 → hazard_o=1 same cycle; next edge loads bubble (RegWrite_o=0, valid_o=0), bubble_cnt +1. Repeat with RDaddr=0 → hazard_o=0.
- Stall hold: load entry with pc_i=0x40, then stall_i=1 for 3 cycles while inputs change → pc_o stays 0x40; counters unchanged.
- Flush vs stall: flush_i=1 and stall_i=1 on the same edge with MemWrite_i=1 → bubble loaded, MemWrite_o=0, ALUOp_o=10, bubble_cnt +1.
- Saturation: CNT_W=4, 20 valid loads → insn_cnt_o=15 and holds at 15.
